muldiv_sequencer: RTL
=====================

# muldiv_sequencer

- Multi-cycle HI/LO unit for the EX stage of the MIPS-lite core.
- Executes MULTU, DIVU, MTHI, MTLO, MFHI and MFLO, selected by the decoded ALU control code from the ALU control decoder.
- Owns the HI/LO architectural registers.
- Sequences iterative shift-add multiply and restoring divide, and holds the pipeline with `stall` while an operation is in flight.

## Interface

Parameters:

- `WIDTH`, default 32: operand and HI/LO width. Iteration count equals `WIDTH`.

Ports:

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op_valid`  in  1  EX holds a valid instruction this cycle.
- `alu_control`  in  `ALU_CONTROL_LENGTH`  decoded operation code (`ALU_CONTROL_*`).
- `src_a`  in  WIDTH  rs value: multiplicand / dividend / MTHI / MTLO data.
- `src_b`  in  WIDTH  rt value: multiplier / divisor.
- `flush`  in  1  synchronous abort of any in-flight operation.
- `stall`  out  1  holds IF/ID/EX.
- `hilo_rdata`  out  WIDTH  HI when `alu_control`=MFHI, LO when MFLO, else 0. Combinational.
- `hi`, `lo`  out  WIDTH  architectural registers.
- `div_by_zero`  out  1  one-cycle pulse when DIVU is accepted with `src_b`=0.

## Operation

- **States:** IDLE, MUL, DIV, DONE. Iteration counter `cnt` is 0..WIDTH-1.
- **IDLE, accepting operations** (op_valid=1):
  - MULTU: latch operands, clear the 2·WIDTH accumulator, cnt=0, go to MUL.
  - DIVU with `src_b`≠0: latch operands, clear the remainder, cnt=0, go to DIV.
  - DIVU with `src_b`=0: no iteration. At the edge: HI←`src_a`, LO←all-ones, `div_by_zero` pulses; go to DONE.
  - MTHI / MTLO: HI or LO ← `src_a` at the edge, no stall. Stay in IDLE.
  - MFHI / MFLO and all other codes: no state change.
- **MUL, one bit per cycle (shift-add):**
  - If multiplier bit[cnt]=1, accumulator += multiplicand << cnt. The sum is full 2·WIDTH width with no overflow possible.
  - At cnt=WIDTH-1: {HI,LO} ← final product, go to DONE.
- **DIV, restoring algorithm, one quotient bit per cycle (MSB first):**
  - rem = {rem, dividend[WIDTH-1-cnt]}.
  - If rem ≥ divisor: subtract and set the quotient bit.
  - At cnt=WIDTH-1: LO ← quotient, HI ← remainder, go to DONE.
- **DONE:** `stall`=0 and the pipeline advances. No new operation is accepted in this cycle, so the same instruction is not re-issued. Next state is IDLE.
- **Stall equation:** `stall` = (IDLE & op_valid & op∈{MULTU,DIVU}) | MUL | DIV, forced to 0 when `flush`=1.
- **Flush:** from any state, go to IDLE at the next edge. HI/LO are not modified, and an accept in the same cycle is suppressed.
- **Reset:** state=IDLE, cnt=0, HI=LO=0, `stall`=0, `div_by_zero`=0, datapath registers cleared. Reset mid-operation discards the operation.
- **MT*/MF* outside IDLE:** cannot occur because the pipeline is stalled. The block ignores them.

## Timing

- **MULTU / DIVU (nonzero divisor):**
  - Accept cycle plus WIDTH iteration cycles, so `stall` is high for WIDTH+1 cycles (33 at default).
  - HI/LO are updated at the last iteration edge and are visible in DONE.
  - The instruction leaves EX at the end of DONE.
- **DIVU by zero:** `stall` high for 1 cycle (the accept cycle). HI/LO are written at that edge.
- **MTHI / MTLO:** 0 stall. The new value is visible on `hi`/`lo` and `hilo_rdata` the next cycle.
- **MFHI / MFLO:** combinational read of current HI/LO in the same cycle. There is no internal bypass of a same-cycle MT write.

## Configuration

- **`MULDIV_FAST_MUL_EN` defined:**
  - MULTU completes in the accept cycle using a single-cycle WIDTH×WIDTH multiplier.
  - {HI,LO} is written at the accept edge, `stall` stays 0, and MUL is never entered.
- **Undefined:** the iterative WIDTH+1-cycle shift-add path described above. DIVU is unaffected either way.

## Test plan

- **Reset:** assert `rst` asynchronously mid-cycle → `hi`=`lo`=0 and `stall`=0 immediately.
- **MULTU 0xFFFFFFFF × 0xFFFFFFFF** → HI=0xFFFFFFFE, LO=0x00000001.
  - `stall` high exactly 33 cycles, then low for DONE.
  - With the fast-multiply macro defined: same result with 0 stall cycles.
- **DIVU 100 / 7** → LO=14, HI=2, `stall` 33 cycles.
- **DIVU 0x80000000 / 1** → LO=0x80000000, HI=0.
- **DIVU 5 / 0** → `div_by_zero` pulses 1 cycle, HI=5, LO=0xFFFFFFFF, `stall` 1 cycle.
- **MTHI 0x12345678, then MFHI** → `hilo_rdata`=0x12345678 with no stall.
  - MTLO 0xCAFEF00D, then MFLO → `hilo_rdata`=0xCAFEF00D.
- **Abort mid-operation:**
  - Flush at DIV iteration 10, after preloading HI=0xAAAA0000 and LO=0x0000BBBB → next cycle IDLE, `stall`=0, HI/LO unchanged.
  - Same scenario with `rst` instead of `flush` → HI=LO=0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - Multi-cycle MULTU/DIVU/MTHI/MTLO/MFHI/MFLO unit owning HI/LO.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; DIVU always iterates.
module muldiv_sequencer #(
   parameter int WIDTH              = 32,
   parameter int ALU_CONTROL_LENGTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          op_valid,
   input  logic [ALU_CONTROL_LENGTH-1:0] alu_control,
   input  logic [WIDTH-1:0]              src_a,
   input  logic [WIDTH-1:0]              src_b,
   input  logic                          flush,
   output logic                          stall,
   output logic [WIDTH-1:0]              hilo_rdata,
   output logic [WIDTH-1:0]              hi,
   output logic [WIDTH-1:0]              lo,
   output logic                          div_by_zero
);

   localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MULTU = ALU_CONTROL_LENGTH'(8);
   localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_DIVU  = ALU_CONTROL_LENGTH'(9);
   localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MTHI  = ALU_CONTROL_LENGTH'(10);
   localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MTLO  = ALU_CONTROL_LENGTH'(11);
   localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MFHI  = ALU_CONTROL_LENGTH'(12);
   localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MFLO  = ALU_CONTROL_LENGTH'(13);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t            state, state_next;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  dividend, divisor, rem, quot;
   logic [WIDTH:0]    rem_shift;
   logic [WIDTH-1:0]  rem_next, quot_next;
   logic              q_bit, last, accept, is_mul, is_div, mul_stalls;

   assign is_mul = (alu_control == ALU_CONTROL_MULTU);
   assign is_div = (alu_control == ALU_CONTROL_DIVU);
   assign accept = (state == IDLE) && op_valid && !flush;
   assign last   = (cnt == CW'(WIDTH - 1));

   // Restoring divide step: dividend is shifted left so its MSB is the next bit in.
   assign rem_shift = {rem, dividend[WIDTH-1]};
   assign q_bit     = (rem_shift >= {1'b0, divisor});
   assign rem_next  = q_bit ? WIDTH'(rem_shift - {1'b0, divisor}) : rem_shift[WIDTH-1:0];
   assign quot_next = {quot[WIDTH-2:0], q_bit};

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] product;
   assign product    = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
   assign mul_stalls = 1'b0;
`else
   logic [2*WIDTH-1:0] acc, mcand, acc_next;
   logic [WIDTH-1:0]   mplier;
   assign acc_next   = acc + (mplier[0] ? mcand : '0);
   assign mul_stalls = 1'b1;
`endif

   always_comb begin
      state_next = state;
      stall      = 1'b0;
      hilo_rdata = '0;
      case (state)
         IDLE: begin
            if (op_valid && ((is_mul && mul_stalls) || is_div))
               stall = 1'b1;
            if (accept && is_mul && mul_stalls)
               state_next = MUL;
            else if (accept && is_div)
               state_next = (src_b == '0) ? DONE : DIV;
         end
         MUL: begin
            stall = 1'b1;
            if (last) state_next = DONE;
         end
         DIV: begin
            stall = 1'b1;
            if (last) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
      if (flush) begin
         state_next = IDLE;
         stall      = 1'b0;
      end
      if (alu_control == ALU_CONTROL_MFHI)
         hilo_rdata = hi;
      else if (alu_control == ALU_CONTROL_MFLO)
         hilo_rdata = lo;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
         dividend    <= '0;
         divisor     <= '0;
         rem         <= '0;
         quot        <= '0;
`ifndef MULDIV_FAST_MUL_EN
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
`endif
      end else begin
         state       <= state_next;
         div_by_zero <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               if (is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                  {hi, lo} <= product;
`else
                  acc    <= '0;
                  mcand  <= {{WIDTH{1'b0}}, src_a};
                  mplier <= src_b;
                  cnt    <= '0;
`endif
               end else if (is_div) begin
                  if (src_b == '0) begin
                     hi          <= src_a;
                     lo          <= '1;
                     div_by_zero <= 1'b1;
                  end else begin
                     dividend <= src_a;
                     divisor  <= src_b;
                     rem      <= '0;
                     quot     <= '0;
                     cnt      <= '0;
                  end
               end else if (alu_control == ALU_CONTROL_MTHI) begin
                  hi <= src_a;
               end else if (alu_control == ALU_CONTROL_MTLO) begin
                  lo <= src_a;
               end
            end
`ifndef MULDIV_FAST_MUL_EN
            MUL: if (!flush) begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (last) {hi, lo} <= acc_next;
            end
`endif
            DIV: if (!flush) begin
               rem      <= rem_next;
               quot     <= quot_next;
               dividend <= dividend << 1;
               cnt      <= cnt + 1'b1;
               if (last) begin
                  lo <= quot_next;
                  hi <= rem_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
